// File: rtl/restador_serial.sv
// Bit-serial subtractor: one full-adder cell computes A + ~B + 1, LSB first.
// Result, borrow and signed overflow are registered on the done pulse.
module restador_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic nb;
  logic sum;
  logic cout;
  logic last;

  always_comb begin
    nb   = ~b_q[0];
    sum  = a_q[0] ^ nb ^ carry_q;
    cout = (a_q[0] & nb) | (carry_q & (a_q[0] ^ nb));
    last = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum, res_q[WIDTH-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          d_d     = res_d;
          bout_d  = ~cout;
          // sum here is the result MSB
          ovf_d   = (a_msb_q ^ b_msb_q) & (sum ^ a_msb_q);
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_restador_serial.sv
// Bench for restador_serial: directed vectors, random operations against
// an arithmetic model, restart, back-to-back and mid-run reset scenarios.
module tb_restador_serial;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] D;
  logic         Bout;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  restador_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .D    (D),
    .Bout (Bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  function automatic void model(input int a, input int b,
                                output int d, output int bo,
                                output int ov);
    int sa, sb, df;
    d  = (a - b + M) % M;
    bo = (a < b) ? 1 : 0;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    df = sa - sb;
    ov = (df > M / 2 - 1 || df < -(M / 2)) ? 1 : 0;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for done; returns latency (-1 on timeout).
  task automatic do_op(input int a, input int b, input bit noise,
                       output int lat, output bit busy_err);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    step;
    start = 1'b0;
    lat = -1;
    busy_err = 1'b0;
    for (int n = 1; n <= 3 * W; n++) begin
      if (noise) begin
        A = W'($urandom);
        B = W'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      step;
      if (busy && done) busy_err = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_err = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({D, Bout, ovf, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_out got=%b exp=0", {D, Bout, ovf, busy, done});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_directed;
    int ta[4] = '{5, 3, 7, 8};
    int tb[4] = '{3, 5, 15, 1};
    int td[4] = '{2, 14, 8, 7};
    int tbo[4] = '{0, 1, 1, 0};
    int tov[4] = '{0, 0, 1, 1};
    int lat;
    bit berr;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 1'b0, lat, berr);
      checks++;
      if (lat != W || berr) begin
        failures++;
        $display("FAIL dir_lat%0d got=%0d berr=%0d exp=%0d", i, lat, berr, W);
      end
      checks++;
      if ({D, Bout, ovf} !== {W'(td[i]), 1'(tbo[i]), 1'(tov[i])}) begin
        failures++;
        $display("FAIL dir_res%0d got D=%0d B=%0d O=%0d exp D=%0d B=%0d O=%0d",
                 i, D, Bout, ovf, td[i], tbo[i], tov[i]);
      end
      step;
      checks++;
      if (done !== 1'b0 || D !== W'(td[i])) begin
        failures++;
        $display("FAIL dir_hold%0d got done=%0d D=%0d exp done=0 D=%0d",
                 i, done, D, td[i]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    int npulse = 0;
    A = W'(9);
    B = W'(4);
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    A = '0;
    B = '0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int n = 0; n < 3 * W; n++) begin
      if (done) npulse++;
      step;
    end
    checks++;
    if (npulse != 1) begin
      failures++;
      $display("FAIL restart_pulses got=%0d exp=1", npulse);
    end
    checks++;
    if (D !== W'(5)) begin
      failures++;
      $display("FAIL restart_d got=%0d exp=5", D);
    end
  endtask

  task automatic test_random;
    int a, b, ed, eb, eo, lat;
    bit berr;
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, M - 1));
      b = int'($urandom_range(0, M - 1));
      model(a, b, ed, eb, eo);
      do_op(a, b, 1'b1, lat, berr);
      checks++;
      if (lat != W || berr) begin
        failures++;
        $display("FAIL rnd_lat a=%0d b=%0d got=%0d berr=%0d exp=%0d",
                 a, b, lat, berr, W);
      end
      checks++;
      if ({D, Bout, ovf} !== {W'(ed), 1'(eb), 1'(eo)}) begin
        failures++;
        $display("FAIL rnd_res a=%0d b=%0d got D=%0d B=%0d O=%0d exp D=%0d B=%0d O=%0d",
                 a, b, D, Bout, ovf, ed, eb, eo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat1 = -1;
    int lat2 = -1;
    A = W'(2);
    B = W'(1);
    start = 1'b1;
    step;
    A = W'(0);
    B = W'(1);
    for (int n = 1; n <= 3 * W; n++) begin
      step;
      if (done) begin
        lat1 = n;
        break;
      end
    end
    checks++;
    if (lat1 != W || D !== W'(1) || Bout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d D=%0d B=%0d exp lat=%0d D=1 B=0",
               lat1, D, Bout, W);
    end
    step;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_noidle got busy=%0d done=%0d exp busy=1 done=0",
               busy, done);
    end
    for (int n = 1; n <= 3 * W; n++) begin
      step;
      if (done) begin
        lat2 = n;
        break;
      end
    end
    checks++;
    if (lat2 != W || D !== W'(15) || Bout !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d D=%0d B=%0d O=%0d exp lat=%0d D=15 B=1 O=0",
               lat2, D, Bout, ovf, W);
    end
  endtask

  task automatic test_reset_midrun;
    int npulse = 0;
    int lat;
    bit berr;
    A = W'(6);
    B = W'(2);
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({D, Bout, ovf, busy, done} !== '0) begin
      failures++;
      $display("FAIL midrst_clear got=%b exp=0", {D, Bout, ovf, busy, done});
    end
    step;
    step;
    rst_n = 1'b1;
    for (int n = 0; n < 2 * W; n++) begin
      step;
      if (done) npulse++;
    end
    checks++;
    if (npulse != 0) begin
      failures++;
      $display("FAIL midrst_nodone got=%0d exp=0", npulse);
    end
    do_op(6, 2, 1'b0, lat, berr);
    checks++;
    if (lat != W || berr || D !== W'(4) || Bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_rerun got lat=%0d D=%0d B=%0d O=%0d exp lat=%0d D=4",
               lat, D, Bout, ovf, W);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_restart_ignored;
    test_random;
    test_back_to_back;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
